// File: rtl/ram_2x4kb_arbiter.sv
// Round-robin arbiter with a grant quantum, sharing one single-port 8 KB word RAM between two masters.
// Define RAM_ARB_STATS_EN to add the stat_conflicts / stat_max_wait counters.
module ram_2x4kb_arbiter #(
  parameter int AW      = 11,
  parameter int DW      = 32,
  parameter int QUANTUM = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              m0_req,
  input  logic [DW/8-1:0]   m0_we,
  input  logic [AW-1:0]     m0_addr,
  input  logic [DW-1:0]     m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DW-1:0]     m0_rdata,
  input  logic              m1_req,
  input  logic [DW/8-1:0]   m1_we,
  input  logic [AW-1:0]     m1_addr,
  input  logic [DW-1:0]     m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DW-1:0]     m1_rdata,
  output logic              ram_en,
  output logic [DW/8-1:0]   ram_we,
  output logic [AW-1:0]     ram_a,
  output logic [DW-1:0]     ram_di,
  input  logic [DW-1:0]     ram_do
`ifdef RAM_ARB_STATS_EN
  ,
  output logic [15:0]       stat_conflicts,
  output logic [7:0]        stat_max_wait
`endif
);

  localparam logic [3:0] QUANT = 4'(QUANTUM);

  logic       last_owner_q, last_owner_d;
  logic [3:0] streak_q, streak_d;
  logic       rd_pend_q, rd_pend_d;
  logic       rd_owner_q, rd_owner_d;
  logic       hold_owner;
  logic       gnt_id;

  // A zero streak means nobody owns the RAM yet, so the owner never holds it then.
  always_comb begin
    m0_gnt     = 1'b0;
    m1_gnt     = 1'b0;
    hold_owner = (streak_q != 4'd0) && (streak_q < QUANT);
    if (!RST) begin
      if (m0_req && m1_req) begin
        m0_gnt = (hold_owner != last_owner_q);
        m1_gnt = !m0_gnt;
      end else begin
        m0_gnt = m0_req;
        m1_gnt = m1_req;
      end
    end
  end

  always_comb begin
    ram_en = m0_gnt | m1_gnt;
    ram_we = '0;
    ram_a  = '0;
    ram_di = '0;
    if (m0_gnt) begin
      ram_we = m0_we;
      ram_a  = m0_addr;
      ram_di = m0_wdata;
    end else if (m1_gnt) begin
      ram_we = m1_we;
      ram_a  = m1_addr;
      ram_di = m1_wdata;
    end
  end

  always_comb begin
    gnt_id       = m1_gnt;
    last_owner_d = last_owner_q;
    streak_d     = streak_q;
    rd_pend_d    = 1'b0;
    rd_owner_d   = rd_owner_q;
    if (ram_en) begin
      if (gnt_id == last_owner_q) begin
        streak_d = (streak_q == 4'hF) ? streak_q : streak_q + 4'd1;
      end else begin
        last_owner_d = gnt_id;
        streak_d     = 4'd1;
      end
      if (ram_we == '0) begin
        rd_pend_d  = 1'b1;
        rd_owner_d = gnt_id;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      last_owner_q <= 1'b1;
      streak_q     <= 4'd0;
      rd_pend_q    <= 1'b0;
      rd_owner_q   <= 1'b0;
    end else begin
      last_owner_q <= last_owner_d;
      streak_q     <= streak_d;
      rd_pend_q    <= rd_pend_d;
      rd_owner_q   <= rd_owner_d;
    end
  end

  // A read still in flight when reset rises must not surface.
  assign m0_rvalid = rd_pend_q && !rd_owner_q && !RST;
  assign m1_rvalid = rd_pend_q &&  rd_owner_q && !RST;
  assign m0_rdata  = m0_rvalid ? ram_do : '0;
  assign m1_rdata  = m1_rvalid ? ram_do : '0;

`ifdef RAM_ARB_STATS_EN
  logic [15:0] conf_q, conf_d;
  logic [7:0]  wait0_q, wait0_d, wait1_q, wait1_d, max_q, max_d;

  always_comb begin
    conf_d  = (m0_req && m1_req && conf_q != 16'hFFFF) ? conf_q + 16'd1 : conf_q;
    wait0_d = (m0_req && !m0_gnt) ? ((wait0_q == 8'hFF) ? wait0_q : wait0_q + 8'd1) : 8'd0;
    wait1_d = (m1_req && !m1_gnt) ? ((wait1_q == 8'hFF) ? wait1_q : wait1_q + 8'd1) : 8'd0;
    max_d   = max_q;
    if (wait0_d > max_d) max_d = wait0_d;
    if (wait1_d > max_d) max_d = wait1_d;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      conf_q  <= 16'd0;
      wait0_q <= 8'd0;
      wait1_q <= 8'd0;
      max_q   <= 8'd0;
    end else begin
      conf_q  <= conf_d;
      wait0_q <= wait0_d;
      wait1_q <= wait1_d;
      max_q   <= max_d;
    end
  end

  assign stat_conflicts = conf_q;
  assign stat_max_wait  = max_q;
`endif

endmodule

// File: tb/tb_ram_2x4kb_arbiter.sv
// Bench for ram_2x4kb_arbiter: two instances (QUANTUM=1 and QUANTUM=3) on shared master inputs,
// each with its own RAM, checked against a rule-level reference model plus directed vectors.
module tb_ram_2x4kb_arbiter;
  localparam int AW = 11;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          m0_req, m1_req;
  logic [3:0]    m0_we, m1_we;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;

  logic          g0 [2], g1 [2], rv0 [2], rv1 [2], en [2];
  logic [DW-1:0] rd0 [2], rd1 [2], di [2], dout [2];
  logic [3:0]    we [2];
  logic [AW-1:0] a [2];
`ifdef RAM_ARB_STATS_EN
  logic [15:0]   sc [2];
  logic [7:0]    smw [2];
`endif

  ram_2x4kb_arbiter #(.AW(AW), .DW(DW), .QUANTUM(1)) u_q1 (
    .CLK(clk), .RST(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(g0[0]), .m0_rvalid(rv0[0]), .m0_rdata(rd0[0]),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(g1[0]), .m1_rvalid(rv1[0]), .m1_rdata(rd1[0]),
    .ram_en(en[0]), .ram_we(we[0]), .ram_a(a[0]), .ram_di(di[0]), .ram_do(dout[0])
`ifdef RAM_ARB_STATS_EN
    , .stat_conflicts(sc[0]), .stat_max_wait(smw[0])
`endif
  );

  ram_2x4kb_arbiter #(.AW(AW), .DW(DW), .QUANTUM(3)) u_q3 (
    .CLK(clk), .RST(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(g0[1]), .m0_rvalid(rv0[1]), .m0_rdata(rd0[1]),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(g1[1]), .m1_rvalid(rv1[1]), .m1_rdata(rd1[1]),
    .ram_en(en[1]), .ram_we(we[1]), .ram_a(a[1]), .ram_di(di[1]), .ram_do(dout[1])
`ifdef RAM_ARB_STATS_EN
    , .stat_conflicts(sc[1]), .stat_max_wait(smw[1])
`endif
  );

  // RAM contents (one per instance) and the model's independent view of them
  logic [DW-1:0] mem    [2][2048];
  logic [DW-1:0] shadow [2][2048];
  logic          cen [2];
  logic [3:0]    cwe [2];
  logic [AW-1:0] ca [2];
  logic [DW-1:0] cdi [2];

  bit            mlast [2];
  int            mstreak [2];
  bit            mpend [2], mown [2];
  logic [DW-1:0] mdat [2];
  bit            eg0 [2], eg1 [2];

  int n_chk = 0;
  int n_pass = 0;

  typedef struct {
    bit       r0, r1;
    bit [1:0] gq1, gq3, rvq1, rvq3;
  } vec_t;
  vec_t tbl [8];

  function automatic logic [DW-1:0] init_word(int i);
    if (i == 11'h005) return 32'hDEADBEEF;
    if (i == 11'h400) return 32'h12345678;
    return 32'hA5000000 ^ (i * 32'h00010203);
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Reference model: arbitration rules, expected RAM command and read return for each instance.
  task automatic model_check();
    for (int k = 0; k < 2; k++) begin
      int            q;
      bit            x0, x1, w, keep, xr0, xr1;
      logic [3:0]    xwe;
      logic [AW-1:0] xa;
      logic [DW-1:0] xd;
      string         p;
      q  = (k == 0) ? 1 : 3;
      p  = $sformatf("q%0d", q);
      x0 = 1'b0;
      x1 = 1'b0;
      if (!rst) begin
        if (m0_req && m1_req) begin
          keep = (mstreak[k] > 0) && (mstreak[k] < q);
          w    = keep ? mlast[k] : !mlast[k];
          x0   = !w;
          x1   = w;
        end else begin
          x0 = m0_req;
          x1 = m1_req;
        end
      end
      xwe = x0 ? m0_we : (x1 ? m1_we : 4'd0);
      xa  = x0 ? m0_addr : (x1 ? m1_addr : '0);
      xd  = x0 ? m0_wdata : (x1 ? m1_wdata : '0);
      xr0 = !rst && mpend[k] && !mown[k];
      xr1 = !rst && mpend[k] && mown[k];
      chk({p, " m0_gnt"}, 32'(g0[k]), 32'(x0));
      chk({p, " m1_gnt"}, 32'(g1[k]), 32'(x1));
      chk({p, " ram_en"}, 32'(en[k]), 32'(x0 | x1));
      chk({p, " ram_we"}, 32'(we[k]), 32'(xwe));
      chk({p, " ram_a"}, 32'(a[k]), 32'(xa));
      chk({p, " ram_di"}, di[k], xd);
      chk({p, " m0_rvalid"}, 32'(rv0[k]), 32'(xr0));
      chk({p, " m1_rvalid"}, 32'(rv1[k]), 32'(xr1));
      chk({p, " m0_rdata"}, rd0[k], xr0 ? mdat[k] : 32'd0);
      chk({p, " m1_rdata"}, rd1[k], xr1 ? mdat[k] : 32'd0);
      if (rst) begin
        mlast[k] = 1'b1; mstreak[k] = 0; mpend[k] = 1'b0; mown[k] = 1'b0;
      end else begin
        mpend[k] = 1'b0;
        if (x0 || x1) begin
          w = x1;
          if (w == mlast[k]) mstreak[k] = (mstreak[k] < 15) ? mstreak[k] + 1 : 15;
          else begin mlast[k] = w; mstreak[k] = 1; end
          if (xwe == 4'd0) begin
            mpend[k] = 1'b1; mown[k] = w; mdat[k] = shadow[k][xa];
          end else begin
            for (int b = 0; b < 4; b++)
              if (xwe[b]) shadow[k][xa][8*b +: 8] = xd[8*b +: 8];
          end
        end
      end
      eg0[k] = x0; eg1[k] = x1;
      cen[k] = en[k]; cwe[k] = we[k]; ca[k] = a[k]; cdi[k] = di[k];
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    model_check();
  endtask

  // Rising edge: the RAM executes the command captured just before it.
  task automatic adv();
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (cen[k]) begin
        if (cwe[k] == 4'd0) dout[k] = mem[k][ca[k]];
        else for (int b = 0; b < 4; b++)
          if (cwe[k][b]) mem[k][ca[k]][8*b +: 8] = cdi[k][8*b +: 8];
      end
    end
    #1;
  endtask

  task automatic step();
    cyc();
    adv();
  endtask

  task automatic new_cmd(output logic [3:0] cwe_o, output logic [AW-1:0] ca_o, output logic [DW-1:0] cd_o);
    cwe_o = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'd0;
    ca_o  = AW'($urandom_range(0, 7)) | ($urandom_range(0, 1) == 1 ? 11'h400 : 11'h000);
    cd_o  = $urandom;
  endtask

  initial begin
    rst = 1'b1;
    m0_req = 1'b1; m0_we = 4'd0; m0_addr = 11'h005; m0_wdata = '0;
    m1_req = 1'b1; m1_we = 4'd0; m1_addr = 11'h401; m1_wdata = '0;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 2048; i++) begin
        mem[k][i]    = init_word(i);
        shadow[k][i] = init_word(i);
      end
      dout[k] = '0; mlast[k] = 1'b1; mstreak[k] = 0; mpend[k] = 1'b0; mown[k] = 1'b0;
      mdat[k] = '0; eg0[k] = 1'b0; eg1[k] = 1'b0; cen[k] = 1'b0;
      cwe[k] = '0; ca[k] = '0; cdi[k] = '0;
    end

    // Reset with both requesting, then a lone m0 read
    cyc();
    chk("rst m0_gnt", 32'(g0[0]), 32'd0);
    chk("rst m1_gnt", 32'(g1[0]), 32'd0);
    chk("rst m0_rvalid", 32'(rv0[0]), 32'd0);
    chk("rst m0_rdata", rd0[0], 32'd0);
    adv();
    rst = 1'b0; m1_req = 1'b0;
    cyc();
    chk("t1 m0_gnt", 32'(g0[0]), 32'd1);
    adv();
    m0_req = 1'b0;
    cyc();
    chk("t1 m0_rvalid", 32'(rv0[0]), 32'd1);
    chk("t1 m0_rdata", rd0[0], 32'hDEADBEEF);
    chk("t1 m1_rvalid", 32'(rv1[0]), 32'd0);
    adv();

    // Continuous contention: QUANTUM=1 alternates, QUANTUM=3 gives three-grant runs
    tbl[0] = '{1, 1, 2'b01, 2'b01, 2'b00, 2'b00};
    tbl[1] = '{1, 1, 2'b10, 2'b01, 2'b01, 2'b01};
    tbl[2] = '{1, 1, 2'b01, 2'b01, 2'b10, 2'b01};
    tbl[3] = '{1, 1, 2'b10, 2'b10, 2'b01, 2'b01};
    tbl[4] = '{1, 1, 2'b01, 2'b10, 2'b10, 2'b10};
    tbl[5] = '{1, 1, 2'b10, 2'b10, 2'b01, 2'b10};
    tbl[6] = '{1, 1, 2'b01, 2'b01, 2'b10, 2'b10};
    tbl[7] = '{0, 0, 2'b00, 2'b00, 2'b01, 2'b01};
    rst = 1'b1;
    step();
    rst = 1'b0; m0_addr = 11'h001; m1_addr = 11'h401;
    for (int i = 0; i < 8; i++) begin
      m0_req = tbl[i].r0; m1_req = tbl[i].r1;
      cyc();
      chk($sformatf("tbl%0d gnt_q1", i), 32'({g1[0], g0[0]}), 32'(tbl[i].gq1));
      chk($sformatf("tbl%0d gnt_q3", i), 32'({g1[1], g0[1]}), 32'(tbl[i].gq3));
      chk($sformatf("tbl%0d rvalid_q1", i), 32'({rv1[0], rv0[0]}), 32'(tbl[i].rvq1));
      chk($sformatf("tbl%0d rvalid_q3", i), 32'({rv1[1], rv0[1]}), 32'(tbl[i].rvq3));
      adv();
    end

    // Partial write to bank 1 followed immediately by a read-back
    m1_req = 1'b1; m1_we = 4'b0011; m1_addr = 11'h400; m1_wdata = 32'h0000ABCD;
    cyc();
    chk("t4 wr gnt", 32'(g1[0]), 32'd1);
    chk("t4 wr ram_we", 32'(we[0]), 32'd3);
    adv();
    m1_we = 4'd0;
    cyc();
    chk("t4 no rvalid after write", 32'(rv1[0]), 32'd0);
    chk("t4 rd gnt", 32'(g1[0]), 32'd1);
    adv();
    m1_req = 1'b0;
    cyc();
    chk("t4 rd rvalid", 32'(rv1[0]), 32'd1);
    chk("t4 rd data", rd1[0], 32'h1234ABCD);
    adv();

    // Reset lands on a read in flight
    m0_req = 1'b1; m0_we = 4'd0; m0_addr = 11'h005;
    cyc();
    chk("t5 m0_gnt", 32'(g0[0]), 32'd1);
    adv();
    rst = 1'b1; m1_req = 1'b1; m1_addr = 11'h401;
    cyc();
    chk("t5 rvalid in rst", 32'(rv0[0]), 32'd0);
    chk("t5 gnt in rst", 32'({g1[0], g0[0]}), 32'd0);
    adv();
    rst = 1'b0;
    cyc();
    chk("t5 rvalid after rst", 32'(rv0[0]), 32'd0);
    chk("t5 contention q1", 32'({g1[0], g0[0]}), 32'b01);
    chk("t5 contention q3", 32'({g1[1], g0[1]}), 32'b01);
    adv();
    m0_req = 1'b0; m1_req = 1'b0;
    step();

`ifdef RAM_ARB_STATS_EN
    rst = 1'b1;
    step();
    rst = 1'b0;
    m0_req = 1'b1; m1_req = 1'b1;
    for (int i = 0; i < 10; i++) step();
    m0_req = 1'b0; m1_req = 1'b0;
    cyc();
    chk("t6 conflicts q1", 32'(sc[0]), 32'd10);
    chk("t6 max_wait q1", 32'(smw[0]), 32'd1);
    chk("t6 conflicts q3", 32'(sc[1]), 32'd10);
    chk("t6 max_wait q3", 32'(smw[1]), 32'd3);
    adv();
    rst = 1'b1;
    step();
    rst = 1'b0;
    cyc();
    chk("t6 conflicts cleared", 32'(sc[0]), 32'd0);
    chk("t6 max_wait cleared", 32'(smw[0]), 32'd0);
    adv();
`endif

    // Random traffic; a pending unaccepted command is held or withdrawn, never changed
    for (int i = 0; i < 400; i++) begin
      if (m0_req && !(eg0[0] && eg0[1])) begin
        if ($urandom_range(0, 7) == 0) m0_req = 1'b0;
      end else begin
        m0_req = ($urandom_range(0, 3) != 0);
        new_cmd(m0_we, m0_addr, m0_wdata);
      end
      if (m1_req && !(eg1[0] && eg1[1])) begin
        if ($urandom_range(0, 7) == 0) m1_req = 1'b0;
      end else begin
        m1_req = ($urandom_range(0, 3) != 0);
        new_cmd(m1_we, m1_addr, m1_wdata);
      end
      rst = ($urandom_range(0, 39) == 0);
      step();
    end
    rst = 1'b0; m0_req = 1'b0; m1_req = 1'b0;
    step();
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
